// File: rtl/sevenseg_sequencer.sv
// Single-digit seven-segment sequencer: latches a binary value, converts it to BCD
// with a serial double-dabble engine, then shows each decimal digit MSB first with a blank gap.
module sevenseg_sequencer #(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 3,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            trigger,
  input  logic [WIDTH-1:0]                                value,
  input  logic                                            lz_blank,
  output logic [6:0]                                      seg,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0]  digit_idx,
  output logic                                            busy,
  output logic                                            done
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int SW   = $clog2(WIDTH + 1);
  localparam int BW   = 4 * DIGITS;

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit digits_ok();
    longint unsigned p10 = 64'd1;
    bit big = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (p10 > 64'd1844674407370955161) big = 1'b1;
      else p10 = p10 * 64'd10;
    end
    if (WIDTH >= 64) return big;
    return big || (p10 > ((64'd1 << WIDTH) - 64'd1));
  endfunction

  if (!digits_ok()) begin : g_digits_check
    $error("sevenseg_sequencer: DIGITS too small for WIDTH");
  end
  if (DWELL_CYCLES < 1) begin : g_dwell_check
    $error("sevenseg_sequencer: DWELL_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW, GAP} state_t;

  state_t            state;
  logic [BW-1:0]     bcd;
  logic [WIDTH-1:0]  sh;
  logic [SW-1:0]     shift_cnt;
  logic [CW-1:0]     cnt;
  logic              lz_q;

  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_nxt;
  logic [WIDTH-1:0]  sh_nxt;
  logic [IW-1:0]     first_sel;
  logic [6:0]        seg_first;
  logic [6:0]        seg_next;
  logic              at_last;
  logic              digit_end;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Index 0 is the most significant nibble, which sits at the top of the register.
  function automatic logic [3:0] digit_at(input logic [BW-1:0] b, input logic [IW-1:0] i);
    logic [BW-1:0] t;
    t = b >> (4 * (DIGITS - 1 - int'(i)));
    return t[3:0];
  endfunction

  function automatic logic [IW-1:0] first_idx(input logic [BW-1:0] b, input logic lz);
    logic [IW-1:0] r;
    r = IW'(DIGITS - 1);
    if (lz) begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        if (digit_at(b, IW'(i)) != 4'd0) r = IW'(i);
      end
    end else begin
      r = '0;
    end
    return r;
  endfunction

  always_comb begin
    bcd_adj            = add3(bcd);
    {bcd_nxt, sh_nxt}  = {bcd_adj, sh} << 1;
    first_sel          = first_idx(bcd_nxt, lz_q);
    seg_first          = seg7(digit_at(bcd_nxt, first_sel));
    seg_next           = seg7(digit_at(bcd, digit_idx + 1'b1));
    at_last            = (digit_idx == IW'(DIGITS - 1));
    digit_end          = ((state == SHOW) && (cnt == '0) && (BLANK_CYCLES == 0)) ||
                         ((state == GAP) && (cnt == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcd       <= '0;
      sh        <= '0;
      shift_cnt <= '0;
      cnt       <= '0;
      lz_q      <= 1'b0;
      seg       <= '0;
      digit_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          seg <= '0;
          if (trigger) begin
            sh        <= value;
            lz_q      <= lz_blank;
            bcd       <= '0;
            shift_cnt <= SW'(WIDTH);
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          bcd       <= bcd_nxt;
          sh        <= sh_nxt;
          shift_cnt <= shift_cnt - 1'b1;
          // Final shift: pick the first digit from the fully converted value.
          if (shift_cnt == SW'(1)) begin
            digit_idx <= first_sel;
            seg       <= seg_first;
            cnt       <= CW'(DWELL_CYCLES - 1);
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (BLANK_CYCLES > 0) begin
            seg   <= '0;
            cnt   <= CW'(BLANK_CYCLES - 1);
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (digit_end) begin
        if (!at_last) begin
          digit_idx <= digit_idx + 1'b1;
          seg       <= seg_next;
          cnt       <= CW'(DWELL_CYCLES - 1);
          state     <= SHOW;
        end else begin
          digit_idx <= '0;
          seg       <= '0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_sequencer.sv
// Bench for sevenseg_sequencer: three configurations compared cycle by cycle against
// a decimal-arithmetic reference trace built from the value and display timing.
module tb_sevenseg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Configurations: 0 = 8b/3d dwell4 blank2, 1 = 8b/3d dwell3 blank0, 2 = 10b/4d dwell3 blank1
  localparam int P_W  [3] = '{8, 8, 10};
  localparam int P_D  [3] = '{3, 3, 4};
  localparam int P_DW [3] = '{4, 3, 3};
  localparam int P_BL [3] = '{2, 0, 1};

  logic       trig_a, trig_b, trig_c;
  logic       lz_a, lz_b, lz_c;
  logic [7:0] val_a, val_b;
  logic [9:0] val_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] idx_a, idx_b, idx_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;

  sevenseg_sequencer #(.WIDTH(8), .DIGITS(3), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .trigger(trig_a), .value(val_a), .lz_blank(lz_a),
    .seg(seg_a), .digit_idx(idx_a), .busy(busy_a), .done(done_a));
  sevenseg_sequencer #(.WIDTH(8), .DIGITS(3), .DWELL_CYCLES(3), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .trigger(trig_b), .value(val_b), .lz_blank(lz_b),
    .seg(seg_b), .digit_idx(idx_b), .busy(busy_b), .done(done_b));
  sevenseg_sequencer #(.WIDTH(10), .DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .trigger(trig_c), .value(val_c), .lz_blank(lz_c),
    .seg(seg_c), .digit_idx(idx_c), .busy(busy_c), .done(done_c));

  int         sel;
  logic [6:0] o_seg;
  logic [1:0] o_idx;
  logic       o_busy, o_done;

  always_comb begin
    o_seg = seg_a; o_idx = idx_a; o_busy = busy_a; o_done = done_a;
    case (sel)
      1: begin o_seg = seg_b; o_idx = idx_b; o_busy = busy_b; o_done = done_b; end
      2: begin o_seg = seg_c; o_idx = idx_c; o_busy = busy_c; o_done = done_c; end
      default: ;
    endcase
  end

  int         checks = 0;
  int         errors = 0;
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Handshake: trigger is a level sampled at a rising edge while the DUT is idle;
  // busy covers the whole run and done pulses for one cycle in the first idle cycle.
  task automatic drive(input int s, input bit t, input int v, input bit lz);
    case (s)
      0: begin trig_a = t; val_a = v[7:0]; lz_a = lz; end
      1: begin trig_b = t; val_b = v[7:0]; lz_b = lz; end
      default: begin trig_c = t; val_c = v[9:0]; lz_c = lz; end
    endcase
  endtask

  // Runs one (or, with hold, two back-to-back) sequences on config s and checks every cycle.
  task automatic test_sequence(input int s, input int v, input bit lz, input int pulse_at,
                               input bit hold, input string tag);
    int w, d, dw, bl, first, reps, last_done;
    int dig [$];
    logic [6:0] exp_q [$];
    int exp_idx [$];
    bit exp_busy [$];
    bit exp_done [$];
    w = P_W[s]; d = P_D[s]; dw = P_DW[s]; bl = P_BL[s];
    for (int i = 0; i < d; i++) begin
      int p = 1;
      for (int j = 0; j < d - 1 - i; j++) p = p * 10;
      dig.push_back((v / p) % 10);
    end
    first = 0;
    if (lz) begin
      first = d - 1;
      for (int i = d - 1; i >= 0; i--) if (dig[i] != 0) first = i;
    end
    reps = hold ? 2 : 1;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < w; i++) begin
        exp_q.push_back(7'h00); exp_idx.push_back(-1); exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
      end
      for (int i = first; i < d; i++) begin
        for (int c = 0; c < dw; c++) begin
          exp_q.push_back(pat[dig[i]]); exp_idx.push_back(i); exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
        end
        for (int c = 0; c < bl; c++) begin
          exp_q.push_back(7'h00); exp_idx.push_back(-1); exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
        end
      end
      exp_q.push_back(7'h00); exp_idx.push_back(-1); exp_busy.push_back(1'b0); exp_done.push_back(1'b1);
    end
    last_done = exp_q.size() - 1;
    exp_q.push_back(7'h00); exp_idx.push_back(-1); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);

    sel = s;
    @(negedge clk);
    drive(s, 1'b1, v, lz);
    @(posedge clk);
    for (int n = 0; n < exp_q.size(); n++) begin
      @(negedge clk);
      if (hold && n < last_done) drive(s, 1'b1, v, lz);
      else if (n + 1 == pulse_at) drive(s, 1'b1, int'($urandom), 1'($urandom_range(0, 1)));
      else drive(s, 1'b0, int'($urandom), 1'($urandom_range(0, 1)));
      checks++;
      if (o_seg !== exp_q[n]) begin
        errors++;
        $display("FAIL %s seg cycle %0d got %h expected %h", tag, n + 1, o_seg, exp_q[n]);
      end
      checks++;
      if (o_busy !== exp_busy[n]) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b expected %b", tag, n + 1, o_busy, exp_busy[n]);
      end
      checks++;
      if (o_done !== exp_done[n]) begin
        errors++;
        $display("FAIL %s done cycle %0d got %b expected %b", tag, n + 1, o_done, exp_done[n]);
      end
      if (exp_idx[n] >= 0) begin
        checks++;
        if (o_idx !== 2'(exp_idx[n])) begin
          errors++;
          $display("FAIL %s digit_idx cycle %0d got %0d expected %0d", tag, n + 1, o_idx, exp_idx[n]);
        end
      end
    end
    drive(s, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 0, 1'b0); drive(1, 1'b0, 0, 1'b0); drive(2, 1'b0, 0, 1'b0);
    sel = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({seg_a, idx_a, busy_a, done_a} !== 11'h0) begin
      errors++;
      $display("FAIL reset_a got seg=%h idx=%0d busy=%b done=%b required all 0", seg_a, idx_a, busy_a, done_a);
    end
    checks++;
    if ({seg_b, busy_b, seg_c, busy_c} !== 16'h0) begin
      errors++;
      $display("FAIL reset_bc got seg_b=%h busy_b=%b seg_c=%h busy_c=%b required 0", seg_b, busy_b, seg_c, busy_c);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || seg_a !== 7'h00 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_trigger got busy=%b seg=%h done=%b required 0", busy_a, seg_a, done_a);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    int v;
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 205, 1'b0);
    @(posedge clk);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      drive(0, 1'b0, 0, 1'b0);
    end
    checks++;
    if (seg_a !== 7'h3F || idx_a !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid_pre got seg=%h idx=%0d required 3f idx 1", seg_a, idx_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({seg_a, idx_a, busy_a, done_a} !== 11'h0) begin
      errors++;
      $display("FAIL reset_mid_async got seg=%h idx=%0d busy=%b done=%b required all 0", seg_a, idx_a, busy_a, done_a);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold got done=%b busy=%b required 0", done_a, busy_a);
      end
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_release got done=%b busy=%b required 0", done_a, busy_a);
      end
    end
    v = $urandom_range(0, 255);
    test_sequence(0, v, 1'b0, 0, 1'b0, "fresh_after_reset");
  endtask

  task automatic test_directed();
    test_sequence(0, 205, 1'b0, 0, 1'b0, "v205");
    test_sequence(0, 7, 1'b1, 0, 1'b0, "v7_lz");
    test_sequence(0, 7, 1'b0, 0, 1'b0, "v7_nolz");
    test_sequence(0, 0, 1'b1, 0, 1'b0, "v0_lz");
    test_sequence(0, 50, 1'b1, 0, 1'b0, "v50_lz");
    test_sequence(1, 255, 1'b0, 0, 1'b0, "v255_noblank");
    test_sequence(1, 11, 1'b1, 0, 1'b0, "v11_noblank_lz");
    test_sequence(2, 1023, 1'b0, 0, 1'b0, "v1023_4dig");
    test_sequence(2, 1000, 1'b1, 0, 1'b0, "v1000_4dig_lz");
  endtask

  task automatic test_busy_trigger();
    test_sequence(0, 205, 1'b0, 14, 1'b0, "pulse_mid_show");
    test_sequence(2, 318, 1'b1, 16, 1'b0, "pulse_mid_show_c");
  endtask

  task automatic test_back_to_back();
    test_sequence(0, 93, 1'b1, 0, 1'b1, "held_trigger");
    test_sequence(1, 100, 1'b0, 0, 1'b1, "held_trigger_noblank");
  endtask

  task automatic test_random();
    for (int i = 0; i < 18; i++) begin
      int s, v;
      bit lz;
      s  = i % 3;
      lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) v = $urandom_range(0, 99);
      else v = $urandom_range(0, (1 << P_W[s]) - 1);
      test_sequence(s, v, lz, 0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_trigger();
    test_back_to_back();
    test_reset_mid_show();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
